pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register. It replaces fixed per-stage DFF banks (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that adds valid/ready backpressure, a 2-entry skid buffer, flush-to-bubble and control-field zeroing. It sits between any two CPU stages. The payload is split into data fields, which are held on a bubble, and control fields (RegWrite, MemWrite, branch, ...), which are forced to 0 on a bubble so a squashed instruction has no architectural effect.

Parameters:
DATA_W, 64, width of the data payload (alu_result, Db, pc, Rd, xfer_size concatenated by the instantiator)
CTRL_W, 8, width of the control payload; zeroed whenever the stage holds a bubble
STALL_CNT_W, 16, width of the saturating backpressure-cycle counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  upstream stage presents an instruction
in_ready  output  1  stage can accept; registered; in_ready = !skid_full
in_data  input  DATA_W  upstream data payload
in_ctrl  input  CTRL_W  upstream control payload
flush  input  1  squash all held contents (branch mispredict); synchronous
out_valid  output  1  head entry holds a valid instruction
out_ready  input  1  downstream accepts head this cycle
out_data  output  DATA_W  head data payload
out_ctrl  output  CTRL_W  head control; all-zero whenever out_valid=0
occupancy  output  2  entries held: 0, 1 or 2
stall_cycles  output  STALL_CNT_W  count of cycles with out_valid && !out_ready, saturating

Behaviour:
- Storage: main entry (head, drives the out_* ports) and skid entry. Each entry has data, ctrl and valid.
- Reset (reset=0, asynchronous): both valid bits=0, all ctrl=0, all data=0, in_ready=1, occupancy=0, stall_cycles=0. Reset takes effect mid-transfer with no handshake completion.
- Transfer definitions: accept = in_valid && in_ready; drain = out_valid && out_ready.
- States: EMPTY (occ 0), ONE (occ 1, main valid), FULL (occ 2).
  - EMPTY: accept -> ONE, data loaded into main. Latency in->out is 1 cycle.
  - ONE: accept && drain -> ONE, main reloaded. accept && !drain -> FULL, in goes to skid. !accept && drain -> EMPTY. Otherwise hold.
  - FULL: in_ready=0, so no accept. drain -> ONE, skid moves to main and skid is cleared. Otherwise hold.
- in_ready depends only on state, never combinationally on out_ready. This breaks the ready path.
- Back-to-back throughput: 1 instruction/cycle when out_ready stays 1.
- flush=1 at a clock edge: next state EMPTY, both valid=0, both ctrl=0, data held. The same-cycle accept is discarded. The same-cycle drain still counts as consumed downstream. flush has priority over every transition.
- Bubble rule: out_ctrl=0 whenever out_valid=0. A held invalid entry's ctrl register is 0, not merely masked.
- Ordering: strict FIFO. The skid entry never bypasses main.
- stall_cycles: +1 per cycle with out_valid && !out_ready. Saturates at all-ones. Cleared only by reset; flush does not clear it.
- Payload is opaque: no arithmetic on data. Widths are passed through unchanged.
- Input in_data/in_ctrl are sampled only on accept. They are don't-care otherwise.

Test Plan:
1. Reset with reset=0 for 2 cycles, then release -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0, stall_cycles=0.
2. Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each, in_ready stays 1, occupancy stays 1.
3. Backpressure: send A=0xA, B=0xB while out_ready=0 -> occupancy=2, in_ready=0, C is not accepted. Raise out_ready -> outputs A, B, C in order. stall_cycles equals the number of held-valid cycles.
4. Flush in FULL with in_valid=1 (D=0xD), ctrl=0xFF -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0, in_ready=1. D never appears at the output.
5. Async reset mid-stream: assert reset=0 between clock edges with occupancy=2 -> outputs clear immediately without a clock edge. After release, the stage accepts new data with 1-cycle latency.
6. Saturation with STALL_CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 and stays 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main (head) entry plus one skid entry, flush-to-bubble.
// Latency: 1 cycle from accept to out_valid; 1 instruction/cycle when out_ready stays high.
// Backpressure: in_ready is a function of registered state only (low when both entries are held).
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data/in_ctrl    upstream handshake and payload
//   flush                                synchronous squash of all held entries
//   out_valid/out_ready/out_data/out_ctrl downstream handshake and head payload
//   occupancy                            number of held entries (0..2)
//   stall_cycles                         saturating count of out_valid && !out_ready cycles
module pipe_stage_reg #(
  parameter int DATA_W      = 64,
  parameter int CTRL_W      = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic accept;
  logic drain;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic clr_main;
  logic clr_skid;

  // Entry valid bits are implied by state: main is valid unless EMPTY, skid only when FULL.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign occupancy = state;
  assign out_data  = main_data;
  // main_ctrl is zeroed whenever main becomes invalid, so no output masking is needed.
  assign out_ctrl  = main_ctrl;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    clr_skid       = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
          clr_main  = 1'b1;
        end
      end
      FULL: begin
        // Skid always moves up into main; it never bypasses it.
        if (drain) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
          clr_skid       = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
        clr_main  = 1'b1;
        clr_skid  = 1'b1;
      end
    endcase
    // A squash overrides everything: any same-cycle accept is dropped, data regs hold.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clr_main       = 1'b1;
      clr_skid       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (load_main_in) begin
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (load_main_skid) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
    end else if (clr_main) begin
      main_ctrl <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (load_skid) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end else if (clr_skid) begin
      skid_ctrl <= '0;
    end
  end

  // Only reset clears the counter; a flush leaves the history intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
